// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: state type and width helper shared by the serial magnitude comparator
package serial_cmp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cyc_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: MSB-first bit-serial compare with early exit and a count of bits examined
module serial_mag_cmp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic                       signed_mode,
  output logic                       busy,
  output logic                       done,
  output logic                       eq,
  output logic                       gt,
  output logic                       lt,
  output logic [cyc_w(WIDTH)-1:0]    cycles
);
  localparam int CW = cyc_w(WIDTH);
  localparam int IW = $clog2(WIDTH);
  state_t         state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic           sm_q, sm_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic           a_bit, b_bit, flip;
  // next state: accept a request when not running, otherwise examine one bit per cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    a_bit   = a_q[idx_q];
    b_bit   = b_q[idx_q];
    flip    = sm_q && (idx_q == IW'(WIDTH - 1));
    if (state_q == RUN) begin
      cyc_d = cyc_q + CW'(1);
      if (a_bit != b_bit) begin
        gt_d    = flip ? b_bit : a_bit;
        lt_d    = flip ? a_bit : b_bit;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end else if (idx_q == '0) begin
        eq_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end else begin
        idx_d = idx_q - IW'(1);
      end
    end else if (start) begin
      a_d     = A;
      b_d     = B;
      sm_d    = signed_mode;
      idx_d   = IW'(WIDTH - 1);
      cyc_d   = '0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
      lt_d    = 1'b0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx_q   <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign eq     = eq_q;
  assign gt     = gt_q;
  assign lt     = lt_q;
  assign cycles = cyc_q;
endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp: directed scoreboard bench for the serial magnitude comparator
module tb_serial_mag_cmp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       signed_mode = 1'b0;
  logic       busy, done, eq, gt, lt;
  logic [3:0] cycles;
  int         checks = 0, failures = 0;
  time        t_acc;
  typedef struct {
    logic       eq, gt, lt;
    logic [3:0] cyc;
    string      tag;
  } exp_t;
  exp_t       sb[$];

  serial_mag_cmp #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .eq(eq), .gt(gt), .lt(lt), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sm, input string tag);
    exp_t e;
    int   k = -1;
    for (int i = 7; i >= 0; i--) if (k < 0 && a[i] != b[i]) k = i;
    e.eq  = (a == b);
    e.gt  = sm ? ($signed(a) > $signed(b)) : (a > b);
    e.lt  = sm ? ($signed(a) < $signed(b)) : (a < b);
    e.cyc = (k < 0) ? 4'd8 : 4'(8 - k);
    e.tag = tag;
    return e;
  endfunction

  task automatic begin_cmp(input logic [7:0] a, input logic [7:0] b, input logic sm, input string tag);
    A = a;
    B = b;
    signed_mode = sm;
    start = 1'b1;
    sb.push_back(model(a, b, sm, tag));
    @(posedge clk);
    t_acc = $time;
    #1;
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    signed_mode = 1'($urandom);
    chk({tag, "_busy"}, 16'(busy), 16'd1);
  endtask

  task automatic wait_done();
    exp_t e;
    int   n = 0;
    bit   seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    e = sb.pop_front();
    chk({e.tag, "_done_seen"}, 16'(seen), 16'd1);
    chk({e.tag, "_latency"}, 16'(($time - t_acc - 5) / 10), 16'(e.cyc));
    chk({e.tag, "_eq_gt_lt"}, {13'd0, eq, gt, lt}, {13'd0, e.eq, e.gt, e.lt});
    chk({e.tag, "_cycles"}, 16'(cycles), 16'(e.cyc));
    chk({e.tag, "_busy_low"}, 16'(busy), 16'd0);
  endtask

  task automatic idle_after(input string tag);
    logic [3:0] r;
    r = {eq, gt, lt, 1'b0};
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 16'(done), 16'd0);
    chk({tag, "_hold"}, {12'd0, eq, gt, lt, 1'b0}, 16'(r));
  endtask

  initial begin
    int nd;
    // reset held with random stimulus
    for (int i = 0; i < 3; i++) begin
      A = 8'($urandom);
      B = 8'($urandom);
      signed_mode = 1'($urandom);
      start = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {7'd0, busy, done, eq, gt, lt, cycles}, 16'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {14'd0, busy, done}, 16'd0);
    begin_cmp(8'h00, 8'h00, 1'b0, "equal");
    wait_done();
    idle_after("equal");
    begin_cmp(8'h81, 8'h0A, 1'b0, "early_uns");
    wait_done();
    idle_after("early_uns");
    begin_cmp(8'h81, 8'h0A, 1'b1, "early_sgn");
    wait_done();
    idle_after("early_sgn");
    begin_cmp(8'h12, 8'h13, 1'b0, "late_lt");
    wait_done();
    begin_cmp(8'h22, 8'h02, 1'b0, "late_gt");
    wait_done();
    idle_after("late_gt");
    // start pulsed mid-run with different operands must be ignored
    begin_cmp(8'h12, 8'h13, 1'b0, "ignore_start");
    @(negedge clk);
    start = 1'b1;
    A = 8'h81;
    B = 8'h0A;
    signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // back-to-back request issued during the done cycle
    chk("b2b_in_done", 16'(done), 16'd1);
    begin_cmp(8'hFF, 8'hFE, 1'b1, "b2b");
    wait_done();
    idle_after("b2b");
    // reset in the middle of a run
    begin_cmp(8'h00, 8'h00, 1'b0, "mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clear", {7'd0, busy, done, eq, gt, lt, cycles}, 16'd0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mid_rst_no_done", 16'(nd), 16'd0);
    // random compares in both modes
    for (int i = 0; i < 8; i++) begin
      begin_cmp(8'($urandom), 8'($urandom), 1'(i & 1), "rand");
      wait_done();
    end
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands, unsigned or two's-complement per request. It is the sequential successor to the team's 4-bit combinational equality comparator. It adds gt/lt results, a start/busy/done handshake, MSB-first early termination and a count of bits examined. It sits between operand registers and control logic that can tolerate multi-cycle latency in exchange for a small area.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits; must be at least 2.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled at each rising edge while state is not RUN.
- A  input  WIDTH  operand A; captured on an accepted start.
- B  input  WIDTH  operand B; captured on an accepted start.
- signed_mode  input  1  1 selects two's-complement compare, 0 selects unsigned; captured on an accepted start.
- busy  output  1  high while the comparison is in progress (state RUN).
- done  output  1  one-cycle pulse marking that the results are valid.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- cycles  output  $clog2(WIDTH+1)  number of bit positions examined, in the range 1..WIDTH.

## Operation
- State machine with states IDLE, RUN and DONE. All outputs are registered.
- IDLE or DONE, start=1:
  - Capture A, B and signed_mode into internal registers.
  - Set idx=WIDTH-1.
  - Clear eq/gt/lt/cycles to 0.
  - Go to RUN.
- IDLE or DONE, start=0: go to or stay in IDLE. Results hold their values.
- RUN, each edge: compare bit a[idx] with b[idx] and increment cycles.
  - Bits differ, unsigned, or signed with idx<WIDTH-1: gt=a[idx], lt=b[idx]; go to DONE.
  - Bits differ, signed, idx==WIDTH-1: the sign bit decides, so gt=b[idx] and lt=a[idx]; go to DONE.
  - Bits equal, idx==0: eq=1; go to DONE.
  - Bits equal, idx>0: decrement idx; stay in RUN.
- DONE lasts exactly one cycle. done=1 during it, and it behaves as IDLE for start acceptance.
- After done, exactly one of eq/gt/lt is 1. eq/gt/lt/cycles hold until the next accepted start.
- start while in RUN is ignored. A, B and signed_mode changes during RUN have no effect.
- Reset asserted at any time, including mid-RUN, immediately forces:
  - state=IDLE;
  - busy, done, eq, gt, lt = 0;
  - cycles=0;
  - captured operands cleared.
- On reset release, no operation is in flight.

## Timing
- Start accepted at edge E0. busy=1 from E0 until the deciding edge.
- Decision occurs at edge E(n), where n is the number of bits examined: n = WIDTH-k, with k the index of the highest differing bit, or n=WIDTH when the operands are equal.
- At E(n): done, eq/gt/lt and cycles=n are updated together and busy falls.
- Latency from start to done is n cycles: minimum 1, maximum WIDTH.
- Back-to-back operation: start=1 during the DONE cycle is accepted at the following edge. Throughput is therefore n+1 cycles per compare.
- cycles is observable while busy as a running count. It is only meaningful when done=1.

## Structure
- Shared package serial_cmp_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a localparam function for the cycles width, $clog2(WIDTH+1).
- Single flat module, no sub-module. The datapath is one bit-select comparator, a down-counter for idx and an up-counter for cycles. Any shift-register or mux implementation of the bit select is acceptable.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 with random inputs -> busy, done, eq, gt, lt = 0 and cycles=0. Assert rst_n=0 mid-RUN -> outputs clear immediately, and no done pulse follows.
- Equality: A=0x00, B=0x00, unsigned -> done at E8; eq=1, gt=0, lt=0, cycles=8.
- Early exit, unsigned: A=0x81, B=0x0A -> done at E1; gt=1, cycles=1.
- Early exit, signed: A=0x81, B=0x0A, signed_mode=1 -> done at E1; lt=1, cycles=1.
- Late difference: A=0x12, B=0x13 -> lt=1, cycles=8. Then A=0x22, B=0x02 -> gt=1, cycles=3.
- Handshake:
  - Pulse start during RUN with other operands -> ignored, and the first result is unchanged.
  - Assert start in the DONE cycle with A=0xFF, B=0xFE, signed_mode=1 -> accepted at the next edge; result gt=1, cycles=8.
